urv_pipe_ctrl: RTL
==================

// Module: urv_pipe_ctrl
// PURPOSE
//  Parametrised pipeline-control unit for uRV-class cores: stall aggregation, post-branch kill shadow, full flush.
//  Sits beside the stage chain (F..W) and drives per-stage stall/kill vectors.
//  Generalises the fixed 4-stage, branch-in-X scheme to N stages and any resolve stage.
//  Adds a flush path and optional performance counters.
// PARAMETERS
//  g_num_stages      4        pipeline stages; index 0 = fetch, N-1 = writeback (2..8)
//  g_bra_stage       2        stage that resolves branches (1..N-1)
//  g_self_stall_mask 4'b1100  bit s=1: stall_req_i[s] also stalls stage s itself
// PORTS
//  clk_i        in   1   clock
//  rst_n_i      in   1   reset, synchronous, active-low
//  stall_req_i  in   N   per-stage stall request
//  bra_i        in   1   branch/jump taken, from stage g_bra_stage
//  flush_i      in   1   full flush request (trap, debug toggle)
//  stall_o      out  N   per-stage stall
//  kill_o       out  N   per-stage kill (stage output becomes invalid)
//  perf_clr_i   in   1   clear perf counters
//  perf_stall_o out  32  cycles with stall_o[0]=1
//  perf_kill_o  out  32  cycles with any kill_o bit set
//  perf_bra_o   out  32  branches taken (bra_i while stall_o[B]=0)
// BEHAVIOUR
//  One clock (clk_i); rst_n_i synchronous, active-low. B = g_bra_stage.
//  stall_o[s] = |stall_req_i[N-1:s+1] | (stall_req_i[s] & g_self_stall_mask[s]); combinational, zero latency.
//  stall_o[N-1] = stall_req_i[N-1] & mask[N-1].
//  Kill shadow hist[B-1:0]: advances only when stall_o[B]=0: hist[0]<=bra_i|flush_i, hist[k]<=hist[k-1].
//  Stalled at B: hist holds; bra_i held by requester; shadow not double-counted.
//  kill_o[0] = bra_i|flush_i; kill_o[s], 1<=s<=B: bra_i|flush_i|(|hist[s-1:0]).
//  kill_o[s], s>B: flush_i only (same cycle).
//  bra_i and flush_i together: behaves as flush_i; hist[0] set once.
//  Back-to-back branches: hist ORs; kill extends until B cycles after last unstalled branch.
//  Reset: hist=0, stall_o/kill_o follow inputs (combinational), perf counters=0.
//  Reset asserted mid-shadow: hist cleared next edge; no residual kill after reset.
//  Output latency: stall_o/kill_o combinational; hist/counters update on clk_i rising edge.
// CONFIGURATION
//  URV_PIPE_PERF_EN defined: three 32-bit counters, wrap 0xFFFFFFFF->0, +1 per qualifying cycle.
//  perf_clr_i zeroes all three next edge (wins over increment).
//  URV_PIPE_PERF_EN undefined: ports present, perf_*_o tied to 0, perf_clr_i ignored, no counter flops.
// STRUCTURE
//  urv_pipe_pkg: stage-index constants (STAGE_F=0, STAGE_D=1, STAGE_X=2, STAGE_W=3), PERF_CNT_W=32.
//  Sub-module urv_pipe_shadow: B-deep kill-history shift reg with enable and sync clear.
//  Top: stall reduction generate-loop, kill OR-tree, perf counters in `ifdef.
// TESTING
//  Defaults; bra_i pulse 1 cycle, no stalls -> kill_o = 4'b0111 (cycle 0), 4'b0110 (+1), 4'b0100 (+2), 0 (+3).
//  stall_req_i[3]=1 for 3 cycles during shadow -> stall_o=4'b1111, kill shadow frozen, resumes after release.
//  stall_req_i[1]=1 only -> stall_o=4'b0001; stall_req_i[2]=1 -> stall_o=4'b0111.
//  flush_i pulse -> kill_o=4'b1111 that cycle, 4'b0110 then 4'b0100 following cycles.
//  rst_n_i low on cycle after bra_i -> hist=0; kill_o=0 next cycle with inputs low.
//  URV_PIPE_PERF_EN, preload 0xFFFFFFFE, 2 stall cycles -> perf_stall_o=0; perf_clr_i with stall -> 0.

Source files
------------

// File: rtl/urv_pipe_pkg.sv
// Shared constants for the uRV pipeline-control slice: stage indices and perf counter width.
package urv_pipe_pkg;

  localparam int unsigned STAGE_F = 0;
  localparam int unsigned STAGE_D = 1;
  localparam int unsigned STAGE_X = 2;
  localparam int unsigned STAGE_W = 3;

  localparam int unsigned PERF_CNT_W = 32;

endpackage

// File: rtl/urv_pipe_shadow.sv
// Kill-history shift register: remembers recent branches/flushes so the stages that were
// fetched behind them are killed as they drain. Shifts only when enabled; sync active-low clear.
module urv_pipe_shadow #(
  parameter int unsigned g_depth = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               en_i,
  input  logic               d_i,
  output logic [g_depth-1:0] hist_o
);

  logic [g_depth-1:0] hist_q, hist_d;

  // Next history: shift in d_i when enabled, otherwise hold.
  always_comb begin
    hist_d = hist_q;
    if (en_i) begin
      hist_d[0] = d_i;
      for (int k = 1; k < int'(g_depth); k++) begin
        hist_d[k] = hist_q[k-1];
      end
    end
  end

  // History register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign hist_o = hist_q;

endmodule

// File: rtl/urv_pipe_ctrl.sv
// Pipeline-control unit: per-stage stall aggregation, post-branch kill shadow and full flush.
// Optional performance counters are built only when URV_PIPE_PERF_EN is defined; otherwise
// the perf outputs are tied to zero and perf_clr_i is ignored.
module urv_pipe_ctrl
  import urv_pipe_pkg::*;
#(
  parameter int unsigned                 g_num_stages      = 4,
  parameter int unsigned                 g_bra_stage       = STAGE_X,
  parameter logic [g_num_stages-1:0]     g_self_stall_mask = 4'b1100
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [g_num_stages-1:0] stall_req_i,
  input  logic                    bra_i,
  input  logic                    flush_i,
  output logic [g_num_stages-1:0] stall_o,
  output logic [g_num_stages-1:0] kill_o,
  input  logic                    perf_clr_i,
  output logic [PERF_CNT_W-1:0]   perf_stall_o,
  output logic [PERF_CNT_W-1:0]   perf_kill_o,
  output logic [PERF_CNT_W-1:0]   perf_bra_o
);

  localparam int unsigned N = g_num_stages;
  localparam int unsigned B = g_bra_stage;

  logic         redirect;
  logic [B-1:0] hist;

  assign redirect = bra_i | flush_i;

  // A stage stalls when any younger-side (later) stage requests, or itself if masked in.
  for (genvar s = 0; s < N; s++) begin : g_stall
    if (s == N - 1) begin : g_last
      assign stall_o[s] = stall_req_i[s] & g_self_stall_mask[s];
    end else begin : g_mid
      assign stall_o[s] = (|stall_req_i[N-1:s+1]) | (stall_req_i[s] & g_self_stall_mask[s]);
    end
  end

  // History only advances when the resolving stage moves, so a held branch is counted once.
  urv_pipe_shadow #(
    .g_depth (B)
  ) u_shadow (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (~stall_o[B]),
    .d_i     (redirect),
    .hist_o  (hist)
  );

  // Stages up to B carry wrong-path work; stages past B are only killed by a flush.
  assign kill_o[0] = redirect;
  for (genvar s = 1; s < N; s++) begin : g_kill
    if (s <= B) begin : g_shadow
      assign kill_o[s] = redirect | (|hist[s-1:0]);
    end else begin : g_flush
      assign kill_o[s] = flush_i;
    end
  end

`ifdef URV_PIPE_PERF_EN
  logic [PERF_CNT_W-1:0] perf_stall_q, perf_stall_d;
  logic [PERF_CNT_W-1:0] perf_kill_q, perf_kill_d;
  logic [PERF_CNT_W-1:0] perf_bra_q, perf_bra_d;

  // Counter next-state: clear dominates, otherwise +1 per qualifying cycle (wraps naturally).
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_kill_d  = perf_kill_q;
    perf_bra_d   = perf_bra_q;
    if (perf_clr_i) begin
      perf_stall_d = '0;
      perf_kill_d  = '0;
      perf_bra_d   = '0;
    end else begin
      if (stall_o[0])          perf_stall_d = perf_stall_q + 1'b1;
      if (|kill_o)             perf_kill_d  = perf_kill_q + 1'b1;
      if (bra_i && !stall_o[B]) perf_bra_d  = perf_bra_q + 1'b1;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      perf_stall_q <= '0;
      perf_kill_q  <= '0;
      perf_bra_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_kill_q  <= perf_kill_d;
      perf_bra_q   <= perf_bra_d;
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_kill_o  = perf_kill_q;
  assign perf_bra_o   = perf_bra_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr_i;

  assign perf_stall_o = '0;
  assign perf_kill_o  = '0;
  assign perf_bra_o   = '0;
`endif

endmodule
